// File: rtl/sqrt_pkg.sv
// Shared types for the integer square-root datapath and its inverse.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH,
        DONE
    } sqrt_inv_state_t;

endpackage

// File: rtl/sqrt_inverse.sv
// Rebuilds operand = root*root + remainder with a radix-2 shift-add loop and
// flags remainders that no floor square root could have produced (rem > 2r).
module sqrt_inverse
    import sqrt_pkg::*;
#(
    parameter int Size = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [Size/2-1:0]   root,
    input  logic [Size/2:0]     remainder,
    output logic                busy,
    output logic                done,
    output logic [Size-1:0]     result,
    output logic                invalid
);

    localparam int Half = Size / 2;
    localparam int CntW = $clog2(Half) + 1;

    sqrt_inv_state_t state, next_state;

    logic [Half-1:0] mcand;
    logic [Half-1:0] mplier;
    logic [Half:0]   rem_q;
    logic [Size-1:0] acc;
    logic [CntW-1:0] cnt;
    logic            done_q;
    logic            invalid_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = CALC;
            CALC:       if (cnt == CntW'(Half - 1)) next_state = FINISH;
            FINISH:     next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            rem_q     <= '0;
            acc       <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand     <= root;
                        mplier    <= root;
                        rem_q     <= remainder;
                        acc       <= '0;
                        cnt       <= '0;
                        done_q    <= 1'b0;
                        invalid_q <= 1'b0;
                    end
                end
                CALC: begin
                    // Multiplier consumed LSB first; weight of the bit is the counter.
                    if (mplier[0])
                        acc <= acc + ({{(Size - Half){1'b0}}, mcand} << cnt);
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CntW'(1);
                end
                FINISH: begin
                    // An out-of-range remainder may wrap the sum; the wrapped value is kept.
                    acc       <= acc + {{(Size - Half - 1){1'b0}}, rem_q};
                    invalid_q <= (rem_q > {mcand, 1'b0});
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == CALC) || (state == FINISH);
    assign done    = done_q;
    assign result  = acc;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_sqrt_inverse.sv
// Scoreboard bench for sqrt_inverse: directed vectors plus sqrt round trips.
module tb_sqrt_inverse;

    localparam int Size = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     root_i = '0;
    logic [32:0]     rem_i = '0;
    logic            busy;
    logic            done;
    logic [63:0]     result;
    logic            invalid;

    sqrt_inverse #(.Size(Size)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .root      (root_i),
        .remainder (rem_i),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];
    logic        done_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every rising done presents one result to compare with the queue head.
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result 0x%h with no pending expectation", result);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("result", result, e[63:0]);
                chk("invalid", {63'd0, invalid}, {63'd0, e[64]});
            end
        end
        done_d <= done;
    end

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        logic [63:0] t64;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t   = r | (32'd1 << b);
            t64 = {32'd0, t};
            if (t64 * t64 <= v) r = t;
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] r, input logic [32:0] m);
        @(negedge clk);
        start  = 1'b1;
        root_i = r;
        rem_i  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge; returns edges until done and busy samples.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: done still %0b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic run_op(input logic [31:0] r, input logic [32:0] m,
                          input logic [63:0] exp_res, input logic exp_inv);
        int lat, bn;
        exp_q.push_back({exp_inv, exp_res});
        issue(r, m);
        wait_done(lat, bn);
    endtask

    initial begin
        int lat, bn;
        logic [63:0] op;
        logic [31:0] r;
        logic [63:0] rsq;

        #2;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_invalid", {63'd0, invalid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Zero operand: latency and busy window.
        exp_q.push_back({1'b0, 64'd0});
        issue(32'd0, 33'd0);
        wait_done(lat, bn);
        chk("latency", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(bn), 64'd33);
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);

        run_op(32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 33'h1_FFFF_FFFF, 64'd0, 1'b1);
        run_op(32'd3, 33'd7, 64'd16, 1'b1);
        run_op(32'd3, 33'd6, 64'd15, 1'b0);

        // A start during CALC must not disturb the running operation.
        exp_q.push_back({1'b0, 64'd25});
        issue(32'd5, 33'd0);
        repeat (8) @(posedge clk);
        issue(32'd9, 33'd0);
        wait_done(lat, bn);
        chk("ignored_start_latency", 64'(lat), 64'd24);
        run_op(32'd9, 33'd0, 64'd81, 1'b0);

        // Asynchronous reset mid-computation discards the operation.
        issue(32'd7, 33'd3);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_invalid", {63'd0, invalid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(32'd12, 33'd4, 64'd148, 1'b0);

        // Round trip through a reference floor square root.
        for (int i = 0; i < 1000; i++) begin
            op  = {$urandom, $urandom};
            r   = isqrt(op);
            rsq = {32'd0, r} * {32'd0, r};
            run_op(r, 33'(op - rsq), op, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
